// File: rtl/nice_traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nice_traffic_pkg                                           |
// | Desc    : Shared types and sizing helpers for the traffic assembler. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nice_traffic_pkg;

  localparam int DEF_BEAT_W = 8;
  localparam int DEF_BEATS  = 4;
  localparam int IDX_W      = $clog2(DEF_BEATS);

  typedef logic [DEF_BEAT_W-1:0]           beat_t;
  typedef logic [DEF_BEAT_W*DEF_BEATS-1:0] word_t;
  typedef logic [DEF_BEATS-1:0]            keep_t;

  // Lane-index width for an arbitrary beat count; never narrower than one bit.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nice_traffic_out_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nice_traffic_out_slot                                      |
// | Desc    : One-entry valid/ready holding register for assembled words.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nice_traffic_out_slot #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  input  logic              up_ready,
  output logic              up_valid,
  output logic [DATA_W-1:0] up_data,
  output logic [KEEP_W-1:0] up_keep,
  output logic              up_last,
  output logic              free,
  output logic              drain
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  assign drain = r_valid & up_ready;
  // Empty or emptying this cycle; combinational from up_ready on purpose.
  assign free  = ~r_valid | up_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_keep  <= load_keep;
      r_last  <= load_last;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign up_valid = r_valid;
  assign up_data  = r_data;
  assign up_keep  = r_keep;
  assign up_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/nice_traffic_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nice_traffic_assembler                                     |
// | Desc    : Packs narrow downstream beats into wide framed upstream    |
// |           words with per-lane keep and packet-last.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nice_traffic_assembler
  import nice_traffic_pkg::*;
#(
  parameter int BEAT_W = 8,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dn_valid,
  output logic                    dn_ready,
  input  logic [BEAT_W-1:0]       dn_data,
  input  logic                    dn_last,
  output logic                    up_valid,
  input  logic                    up_ready,
  output logic [BEAT_W*BEATS-1:0] up_data,
  output logic [BEATS-1:0]        up_keep,
  output logic                    up_last,
  output logic [CNT_W-1:0]        words_out
);

  localparam int c_IDX_W  = idx_width(BEATS);
  localparam int c_WORD_W = BEAT_W * BEATS;

  logic [c_WORD_W-1:0] r_acc;
  logic [BEATS-1:0]    r_kacc;
  logic [c_IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]    r_words;

  logic                w_free;
  logic                w_drain;
  logic                w_accept;
  logic                w_at_end;
  logic                w_complete;
  logic [BEATS-1:0]    w_lane_sel;
  logic [c_WORD_W-1:0] w_word;
  logic [BEATS-1:0]    w_keep;

  assign w_accept   = dn_valid & w_free;
  assign w_at_end   = (r_idx == c_IDX_W'(BEATS - 1));
  assign w_complete = w_accept & (w_at_end | dn_last);

  // The word as it looks with the current beat merged into lane idx.
  for (genvar l = 0; l < BEATS; l++) begin : g_lane
    assign w_lane_sel[l]                = (r_idx == c_IDX_W'(l));
    assign w_word[l*BEAT_W +: BEAT_W]   = w_lane_sel[l] ? dn_data : r_acc[l*BEAT_W +: BEAT_W];
  end

  assign w_keep = r_kacc | w_lane_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_kacc <= '0;
      r_idx  <= '0;
    end else if (w_complete) begin
      r_acc  <= '0;
      r_kacc <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_acc  <= w_word;
      r_kacc <= w_keep;
      r_idx  <= r_idx + c_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words <= '0;
    end else if (w_drain) begin
      r_words <= r_words + CNT_W'(1);
    end
  end

  nice_traffic_out_slot #(
    .DATA_W (c_WORD_W),
    .KEEP_W (BEATS)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_complete),
    .load_data (w_word),
    .load_keep (w_keep),
    .load_last (dn_last),
    .up_ready  (up_ready),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_keep   (up_keep),
    .up_last   (up_last),
    .free      (w_free),
    .drain     (w_drain)
  );

  assign dn_ready  = w_free;
  assign words_out = r_words;

endmodule
`default_nettype wire

// File: tb/tb_nice_traffic_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_nice_traffic_assembler                                  |
// | Desc    : Randomized and directed bench with a beat-queue model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nice_traffic_assembler;
  import nice_traffic_pkg::*;

  localparam int BW = 8;
  localparam int NB = 4;
  localparam int CW = 16;
  localparam int WW = BW * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dn_valid = 1'b0;
  logic          dn_ready;
  beat_t         dn_data = '0;
  logic          dn_last = 1'b0;
  logic          up_valid;
  logic          up_ready = 1'b0;
  logic [WW-1:0] up_data;
  logic [NB-1:0] up_keep;
  logic          up_last;
  logic [CW-1:0] words_out;

  nice_traffic_assembler #(.BEAT_W(BW), .BEATS(NB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .dn_data   (dn_data),
    .dn_last   (dn_last),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_keep   (up_keep),
    .up_last   (up_last),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: beats of the packet in progress plus the one visible output word.
  logic [BW-1:0] cur[$];
  logic          m_valid;
  logic          m_pristine;
  logic [WW-1:0] m_data;
  logic [NB-1:0] m_keep;
  logic          m_last;
  logic [CW-1:0] m_words;

  typedef struct packed {
    logic [WW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } word_s;
  word_s obs[$];
  int    stalls = 0;
  bit    s_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cur.delete();
    m_valid    = 1'b0;
    m_pristine = 1'b1;
    m_data     = '0;
    m_keep     = '0;
    m_last     = 1'b0;
    m_words    = '0;
  endfunction

  task automatic compare();
    chk("dn_ready", dn_ready, !m_valid || up_ready);
    chk("up_valid", up_valid, m_valid);
    if (m_valid || m_pristine) begin
      chk("up_data", up_data, m_data);
      chk("up_keep", up_keep, m_keep);
      chk("up_last", up_last, m_last);
    end
    chk("words_out", words_out, m_words);
  endtask

  // Check outputs before the edge, advance the model across it, end at negedge.
  task automatic step();
    bit            hs, acc, rn, lst;
    logic [BW-1:0] d;
    word_s         w;
    #1;
    compare();
    if (dn_valid && !dn_ready) stalls++;
    if (up_valid && up_ready) begin
      w.d = up_data; w.k = up_keep; w.l = up_last;
      obs.push_back(w);
    end
    rn  = rst_n;
    hs  = m_valid && up_ready;
    acc = dn_valid && (!m_valid || up_ready);
    s_acc = acc && rn;
    d   = dn_data;
    lst = dn_last;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (hs) begin
        m_words = m_words + 1'b1;
        m_valid = 1'b0;
      end
      if (acc) begin
        cur.push_back(d);
        if (cur.size() == NB || lst) begin
          m_data = '0;
          foreach (cur[i]) m_data[i*BW +: BW] = cur[i];
          m_keep     = NB'((1 << cur.size()) - 1);
          m_last     = lst;
          m_valid    = 1'b1;
          m_pristine = 1'b0;
          cur.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    dn_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [BW-1:0] d, input logic l);
    dn_valid = 1'b1;
    dn_data  = d;
    dn_last  = l;
    s_acc    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (s_acc) break;
    end
    if (!s_acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: beat %0h not accepted within 50 cycles", d);
    end
    dn_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    dn_valid = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    up_ready = 1'b1;

    // Full packet ending on the last lane.
    obs.delete();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    idle(2);
    chk("t1_count", obs.size(), 1);
    chk("t1_data", obs[0].d, 32'h44332211);
    chk("t1_keep", obs[0].k, 4'b1111);
    chk("t1_last", obs[0].l, 1);
    chk("t1_words", words_out, 1);

    // Short packet.
    obs.delete();
    send(8'hAA, 0); send(8'hBB, 1);
    idle(2);
    chk("t2_data", obs[0].d, 32'h0000BBAA);
    chk("t2_keep", obs[0].k, 4'b0011);
    chk("t2_last", obs[0].l, 1);

    // Back-to-back beats, no stall expected.
    obs.delete();
    stalls = 0;
    for (int i = 1; i <= 8; i++) send(BW'(i), i == 8);
    idle(2);
    chk("t3_count", obs.size(), 2);
    chk("t3_w0", obs[0].d, 32'h04030201);
    chk("t3_l0", obs[0].l, 0);
    chk("t3_w1", obs[1].d, 32'h08070605);
    chk("t3_l1", obs[1].l, 1);
    chk("t3_stalls", stalls, 0);

    // Back-pressure with a full slot.
    obs.delete();
    up_ready = 1'b0;
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    dn_valid = 1'b1; dn_data = 8'h50; dn_last = 1'b0;
    #1;
    chk("t4_stall_ready", dn_ready, 0);
    chk("t4_hold_data", up_data, 32'h40302010);
    step(); step();
    chk("t4_hold_data2", up_data, 32'h40302010);
    up_ready = 1'b1;
    #1;
    chk("t4_release_ready", dn_ready, 1);
    step();
    send(8'h60, 0); send(8'h70, 0); send(8'h80, 1);
    idle(2);
    chk("t4_count", obs.size(), 2);
    chk("t4_w0", obs[0].d, 32'h40302010);
    chk("t4_w1", obs[1].d, 32'h80706050);
    chk("t4_l1", obs[1].l, 1);

    // Single-beat packet.
    obs.delete();
    send(8'h5A, 1);
    idle(2);
    chk("t5_data", obs[0].d, 32'h0000005A);
    chk("t5_keep", obs[0].k, 4'b0001);

    // Reset mid-packet.
    send(8'hE1, 0); send(8'hE2, 0);
    do_reset();
    obs.delete();
    idle(3);
    chk("t6_nothing", obs.size(), 0);
    send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 1);
    idle(2);
    chk("t6_count", obs.size(), 1);
    chk("t6_data", obs[0].d, 32'hC4C3C2C1);
    chk("t6_words", words_out, 1);

    // Randomized traffic with random back-pressure and one mid-run reset.
    s_acc = 1'b0;
    dn_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if (!(dn_valid && !s_acc)) begin
        dn_valid = ($urandom_range(0, 9) < 7);
        dn_data  = BW'($urandom);
        dn_last  = ($urandom_range(0, 3) == 0);
      end
      up_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Counter wrap through continuous single-beat packets.
    do_reset();
    up_ready = 1'b1;
    dn_valid = 1'b1;
    dn_last  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      dn_data = BW'($urandom);
      step();
    end
    idle(2);
    chk("wrap_max", words_out, 16'hFFFF);
    send(8'h77, 1);
    idle(2);
    chk("wrap_zero", words_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
